output_drain: RTL

OUTPUT_DRAIN -- requirements
Module: output_drain

---
 rtl/accel_pkg.sv | 29 ++
 rtl/output_drain_if.sv | 41 ++++
 rtl/output_drain_hold.sv | 42 ++++
 rtl/output_drain.sv | 132 +++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared accelerator constants, drain FSM state encoding and entry-count helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package accel_pkg;

    localparam int ENTRIES     = 32;
    localparam int ENTRY_WORDS = 64;
    localparam int WORD_W      = 32;
    localparam int PTR_W       = 5;
    localparam int CNT_W       = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_STREAM,
        ST_DONE
    } drain_state_t;

    // Index of the final entry to drain; requests beyond the buffer depth
    // saturate at the last physical entry. Meaningless for n == 0.
    function automatic logic [PTR_W-1:0] last_entry(input logic [CNT_W-1:0] n);
        if (n > CNT_W'(ENTRIES)) begin
            return PTR_W'(ENTRIES - 1);
        end
        return PTR_W'(n - 1'b1);
    endfunction

endpackage

// File: rtl/output_drain_if.sv
// Buffer read port plus outbound beat stream of the output drain.
// Latency: n/a (wiring only).
// Backpressure: m_ready from the slave stalls the beat stream.
interface output_drain_if #(
    parameter int LANES = 4
);
    import accel_pkg::*;

    logic              buf_read_en;
    logic [1:0]        buf_sub_tile_idx;
    logic [2:0]        buf_unit_tile_idx;
    logic [WORD_W-1:0] buf_rdata [ENTRY_WORDS];

    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data [LANES];
    logic              m_last;

    modport master (
        output buf_read_en,
        output buf_sub_tile_idx,
        output buf_unit_tile_idx,
        input  buf_rdata,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    modport slave (
        input  buf_read_en,
        input  buf_sub_tile_idx,
        input  buf_unit_tile_idx,
        output buf_rdata,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );

endinterface

// File: rtl/output_drain_hold.sv
// Holds one captured 64-word buffer entry and selects the current beat's lanes.
// Latency: capture takes effect on the next edge; beat select is combinational.
// Backpressure: none internally; contents only change on capture, so a stalled beat stays stable.
module output_drain_hold
    import accel_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int BEAT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [WORD_W-1:0] rdata [ENTRY_WORDS],
    input  logic [BEAT_W-1:0] beat,
    output logic [WORD_W-1:0] data  [LANES]
);

    localparam int IDX_W = $clog2(ENTRY_WORDS);

    logic [WORD_W-1:0] hold [ENTRY_WORDS];

    // Snapshot the whole entry when the read data is valid; cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRY_WORDS; i++) begin
                hold[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < ENTRY_WORDS; i++) begin
                hold[i] <= rdata[i];
            end
        end
    end

    // Beat b presents words b*LANES .. b*LANES+LANES-1.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            data[k] = hold[IDX_W'(int'(beat) * LANES + k)];
        end
    end

endmodule

// File: rtl/output_drain.sv
// Drains N output-buffer entries as a stream of LANES-word beats, entry 0 first.
// Latency: per entry 1 request + READ_LAT wait + 64/LANES beat cycles; done one cycle after the last beat.
// Backpressure: m_ready low holds the current beat (data and last) and stalls the drain.
module output_drain
    import accel_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int READ_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_entries,
    output logic             busy,
    output logic             done,
    output_drain_if.master   bus
);

    localparam int BEATS  = ENTRY_WORDS / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    drain_state_t      state, state_nxt;
    logic [PTR_W-1:0]  ptr, ptr_nxt;
    logic [PTR_W-1:0]  n_last, n_last_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    logic [LAT_W-1:0]  wait_cnt, wait_nxt;
    logic              capture;
    logic              final_beat;

    assign final_beat = (beat == BEAT_W'(BEATS - 1));

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            n_last   <= '0;
            beat     <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            n_last   <= n_last_nxt;
            beat     <= beat_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next-state and counter updates; start only matters in IDLE.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        n_last_nxt = n_last;
        beat_nxt   = beat;
        wait_nxt   = wait_cnt;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    ptr_nxt  = '0;
                    beat_nxt = '0;
                    if (num_entries == '0) begin
                        // Nothing to read: report completion straight away.
                        state_nxt = ST_DONE;
                    end else begin
                        n_last_nxt = last_entry(num_entries);
                        state_nxt  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                wait_nxt  = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == LAT_W'(READ_LAT - 1)) begin
                    // Read data is valid during this last wait cycle.
                    capture   = 1'b1;
                    beat_nxt  = '0;
                    state_nxt = ST_STREAM;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            ST_STREAM: begin
                if (bus.m_ready) begin
                    if (final_beat) begin
                        if (ptr == n_last) begin
                            state_nxt = ST_DONE;
                        end else begin
                            ptr_nxt   = ptr + 1'b1;
                            state_nxt = ST_REQ;
                        end
                    end else begin
                        beat_nxt = beat + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status, read strobe and stream qualifiers decoded from state; all low in IDLE and reset.
    always_comb begin
        busy                  = (state != ST_IDLE);
        done                  = (state == ST_DONE);
        bus.buf_read_en       = (state == ST_REQ);
        bus.buf_sub_tile_idx  = (state == ST_REQ) ? ptr[4:3] : 2'b00;
        bus.buf_unit_tile_idx = (state == ST_REQ) ? ptr[2:0] : 3'b000;
        bus.m_valid           = (state == ST_STREAM);
        bus.m_last            = (state == ST_STREAM) && final_beat && (ptr == n_last);
    end

    output_drain_hold #(
        .LANES  (LANES),
        .BEAT_W (BEAT_W)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .rdata   (bus.buf_rdata),
        .beat    (beat),
        .data    (bus.m_data)
    );

endmodule
